// File: rtl/approx_mul_sweep_ctrl_if.sv
// Operand/product bus between the sweep controller and the approximate multiplier.
// The controller holds the master modport; the multiplier under test holds the slave.
interface approx_mul_sweep_ctrl_if #(
  parameter int BIT = 8
);
  logic [BIT-1:0]   x_o;
  logic [BIT-1:0]   y_o;
  logic [2*BIT-1:0] z_i;

  modport master (output x_o, output y_o, input z_i);
  modport slave  (input x_o, input y_o, output z_i);
endinterface

// File: rtl/approx_mul_sweep_ctrl.sv
// Exhaustive operand sweep of an approximate BITxBIT multiplier with error metric
// accumulation (sum |err|, signed sum, max |err| with operands, error count).
module approx_mul_sweep_ctrl #(
  parameter int BIT     = 8,
  parameter int DUT_LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  approx_mul_sweep_ctrl_if.master mul,
  output logic [4*BIT-1:0]      sum_abs_err,
  output logic [4*BIT:0]        sum_err,
  output logic [2*BIT-1:0]      max_abs_err,
  output logic [BIT-1:0]        worst_x,
  output logic [BIT-1:0]        worst_y,
  output logic [2*BIT:0]        err_count
);
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
  localparam logic [BIT-1:0] OP_MAX = '1;
  localparam int LAT_W = 3;

  state_t           state_reg, state_next;
  logic [BIT-1:0]   x_reg, y_reg;
  logic [LAT_W-1:0] drain_reg;
  logic             done_reg;
  logic             accept, kill, issue, last_pair;

  assign accept    = start && (state_reg == IDLE || state_reg == DONE);
  assign kill      = abort && (state_reg == SWEEP || state_reg == DRAIN);
  assign issue     = (state_reg == SWEEP) && !kill;
  assign last_pair = (x_reg == OP_MAX) && (y_reg == OP_MAX);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (start) state_next = SWEEP;
      SWEEP: begin
        if (abort)          state_next = IDLE;
        else if (last_pair) state_next = (DUT_LAT > 0) ? DRAIN : DONE;
      end
      DRAIN: begin
        if (abort)                                state_next = IDLE;
        else if (drain_reg == LAT_W'(DUT_LAT - 1)) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == SWEEP) || (state_reg == DRAIN);
    done = done_reg;
  end

  assign mul.x_o = x_reg;
  assign mul.y_o = y_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg     <= '0;
      y_reg     <= '0;
      drain_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg  <= (state_next == DONE) && (state_reg != DONE);
      drain_reg <= (state_reg == DRAIN) ? drain_reg + 1'b1 : '0;
      if (accept) begin
        x_reg <= '0;
        y_reg <= '0;
      end else if (issue) begin
        y_reg <= y_reg + 1'b1;
        if (y_reg == OP_MAX) x_reg <= x_reg + 1'b1;
      end
    end
  end

  // Delay line keeps each pair's operands aligned with its product from the multiplier.
  logic           d_valid;
  logic [BIT-1:0] d_x, d_y;

  generate
    if (DUT_LAT == 0) begin : g_no_pipe
      assign d_valid = issue;
      assign d_x     = x_reg;
      assign d_y     = y_reg;
    end else begin : g_pipe
      logic           v_reg  [DUT_LAT];
      logic [BIT-1:0] px_reg [DUT_LAT];
      logic [BIT-1:0] py_reg [DUT_LAT];
      for (genvar gi = 0; gi < DUT_LAT; gi++) begin : g_stage
        logic           v_in;
        logic [BIT-1:0] x_in, y_in;
        if (gi == 0) begin : g_head
          assign v_in = issue;
          assign x_in = x_reg;
          assign y_in = y_reg;
        end else begin : g_tail
          assign v_in = v_reg[gi-1];
          assign x_in = px_reg[gi-1];
          assign y_in = py_reg[gi-1];
        end
        always_ff @(posedge clk) begin
          if (rst || kill || accept) v_reg[gi] <= 1'b0;
          else                       v_reg[gi] <= v_in;
          px_reg[gi] <= x_in;
          py_reg[gi] <= y_in;
        end
      end
      assign d_valid = v_reg[DUT_LAT-1];
      assign d_x     = px_reg[DUT_LAT-1];
      assign d_y     = py_reg[DUT_LAT-1];
    end
  endgenerate

  logic [2*BIT-1:0]      prod;
  logic signed [2*BIT:0] err;
  logic [2*BIT:0]        neg_err;
  logic [2*BIT-1:0]      abs_err;

  assign prod    = {{BIT{1'b0}}, d_x} * {{BIT{1'b0}}, d_y};
  assign err     = $signed({1'b0, mul.z_i}) - $signed({1'b0, prod});
  assign neg_err = -err;
  assign abs_err = err[2*BIT] ? neg_err[2*BIT-1:0] : err[2*BIT-1:0];

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      sum_abs_err <= '0;
      sum_err     <= '0;
      max_abs_err <= '0;
      worst_x     <= '0;
      worst_y     <= '0;
      err_count   <= '0;
    end else if (d_valid && !kill) begin
      sum_abs_err <= sum_abs_err + (4*BIT)'(abs_err);
      sum_err     <= sum_err + {{(2*BIT){err[2*BIT]}}, err};
      err_count   <= err_count + {{(2*BIT){1'b0}}, (err != 0)};
      // Strict compare keeps the earliest pair in sweep order on ties.
      if (abs_err > max_abs_err) begin
        max_abs_err <= abs_err;
        worst_x     <= d_x;
        worst_y     <= d_y;
      end
    end
  end
endmodule

// File: tb/tb_approx_mul_sweep_ctrl.sv
// Directed bench: two controller instances (latency 0 and 2) each driving a behavioural
// multiplier whose error pattern is selected by mode; expected sweep results queued per start.
module tb_approx_mul_sweep_ctrl;
  localparam int BIT = 4;
  localparam int N   = 1 << (2*BIT);

  typedef struct {
    logic [15:0] sum_abs;
    logic [16:0] sum_err;
    logic [7:0]  max_abs;
    logic [3:0]  wx;
    logic [3:0]  wy;
    logic [8:0]  cnt;
    int          done_rel;
  } exp_t;

  exp_t sb_q[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  bit   sel = 1'b0;
  int   mode = 0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  approx_mul_sweep_ctrl_if #(.BIT(BIT)) m0 ();
  approx_mul_sweep_ctrl_if #(.BIT(BIT)) m2 ();

  // Combinational multiplier: exact, or LSB forced to 0 in mode 1.
  logic [7:0] p0;
  always_comb p0 = 8'(m0.x_o) * 8'(m0.y_o);
  assign m0.z_i = (mode == 1) ? (p0 & 8'hFE) : p0;

  // Two-stage multiplier: exact except 15x15 returns 0 in mode 2.
  logic [7:0] r1, r2;
  always @(posedge clk) begin
    r1 <= (mode == 2 && m2.x_o == 4'd15 && m2.y_o == 4'd15) ? 8'd0 : 8'(m2.x_o) * 8'(m2.y_o);
    r2 <= r1;
  end
  assign m2.z_i = r2;

  logic        start0, abort0, start2, abort2;
  logic        busy0, done0, busy2, done2;
  logic [15:0] sae0, sae2;
  logic [16:0] se0, se2;
  logic [7:0]  mae0, mae2;
  logic [3:0]  wx0, wy0, wx2, wy2;
  logic [8:0]  ec0, ec2;

  assign start0 = start & ~sel;
  assign abort0 = abort & ~sel;
  assign start2 = start & sel;
  assign abort2 = abort & sel;

  approx_mul_sweep_ctrl #(.BIT(BIT), .DUT_LAT(0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .busy(busy0), .done(done0),
    .mul(m0.master), .sum_abs_err(sae0), .sum_err(se0), .max_abs_err(mae0),
    .worst_x(wx0), .worst_y(wy0), .err_count(ec0)
  );

  approx_mul_sweep_ctrl #(.BIT(BIT), .DUT_LAT(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .busy(busy2), .done(done2),
    .mul(m2.master), .sum_abs_err(sae2), .sum_err(se2), .max_abs_err(mae2),
    .worst_x(wx2), .worst_y(wy2), .err_count(ec2)
  );

  logic        o_busy, o_done;
  logic [3:0]  o_x, o_y, o_wx, o_wy;
  logic [15:0] o_sae;
  logic [16:0] o_se;
  logic [7:0]  o_mae;
  logic [8:0]  o_ec;

  always_comb begin
    if (sel) begin
      o_busy = busy2; o_done = done2; o_x = m2.x_o; o_y = m2.y_o;
      o_sae = sae2; o_se = se2; o_mae = mae2; o_wx = wx2; o_wy = wy2; o_ec = ec2;
    end else begin
      o_busy = busy0; o_done = done0; o_x = m0.x_o; o_y = m0.y_o;
      o_sae = sae0; o_se = se0; o_mae = mae0; o_wx = wx0; o_wy = wy0; o_ec = ec0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_x"}, o_x, 0);
    check({tag, "_y"}, o_y, 0);
    check({tag, "_sae"}, o_sae, 0);
    check({tag, "_se"}, o_se, 0);
    check({tag, "_mae"}, o_mae, 0);
    check({tag, "_wx"}, o_wx, 0);
    check({tag, "_wy"}, o_wy, 0);
    check({tag, "_ec"}, o_ec, 0);
  endtask

  function automatic exp_t mk(int sa, int se, int mx, int wx, int wy, int cnt, int drel);
    exp_t e;
    e.sum_abs = 16'(sa);
    e.sum_err = 17'(se);
    e.max_abs = 8'(mx);
    e.wx = 4'(wx);
    e.wy = 4'(wy);
    e.cnt = 9'(cnt);
    e.done_rel = drel;
    return e;
  endfunction

  // One sweep started in cycle 0; optional extra start pulse, abort (with start) or reset.
  task automatic run(input bit s, input int m, input int pulse_at, input int abort_at,
                     input int rst_at, input bit expect_done, input exp_t e);
    int   t0;
    int   stop_rel;
    int   done_at;
    bit   seen;
    exp_t got;
    sel  = s;
    mode = m;
    if (expect_done) sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    seen = 1'b0;
    done_at = -1;
    stop_rel = expect_done ? N + 30 : ((abort_at > 0) ? abort_at : rst_at) + 8;
    for (int rel = 1; rel <= stop_rel && !seen; rel++) begin
      @(posedge clk); #1;
      start = (rel == pulse_at) || (rel == abort_at);
      abort = (rel == abort_at);
      rst   = (rel == rst_at);
      @(negedge clk);
      if (rel == 1) begin
        check("first_busy", o_busy, 1);
        check("first_x", o_x, 0);
        check("first_y", o_y, 0);
        check("first_sae_clear", o_sae, 0);
        check("first_ec_clear", o_ec, 0);
      end
      if (expect_done && rel == 20) begin
        check("pair19_x", o_x, 1);
        check("pair19_y", o_y, 3);
      end
      if (expect_done && rel == N) begin
        check("last_x", o_x, 15);
        check("last_y", o_y, 15);
        check("last_busy", o_busy, 1);
      end
      if (abort_at > 0 && rel > abort_at) begin
        check("abort_busy", o_busy, 0);
        check("abort_done", o_done, 0);
      end
      if (rst_at > 0 && rel == rst_at + 1) check_all_zero("rst");
      if (rst_at > 0 && rel > rst_at + 1) check("rst_no_done", o_done, 0);
      if (expect_done && o_done === 1'b1) begin
        seen = 1'b1;
        done_at = t0 + rel;
        got = sb_q.pop_front();
        check("done_cycle", rel, got.done_rel);
        check("done_busy", o_busy, 0);
        check("sum_abs_err", o_sae, got.sum_abs);
        check("sum_err", o_se, got.sum_err);
        check("max_abs_err", o_mae, got.max_abs);
        check("worst_x", o_wx, got.wx);
        check("worst_y", o_wy, got.wy);
        check("err_count", o_ec, got.cnt);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    if (expect_done) begin
      check("done_seen", seen, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("done_one_cycle", o_done, 0);
      check("done_hold_busy", o_busy, 0);
    end
    $display("sweep inst=%0d mode=%0d done_cycle=%0d sae=%0d se=%0d mae=%0d worst=(%0d,%0d) ec=%0d",
             s ? 2 : 0, m, done_at, o_sae, $signed(o_se), o_mae, o_wx, o_wy, o_ec);
  endtask

  exp_t e_zero, e_lsb, e_225;

  initial begin
    e_zero = mk(0, 0, 0, 0, 0, 0, N + 1);
    e_lsb  = mk(64, -64, 1, 1, 1, 64, N + 1);
    e_225  = mk(225, -225, 225, 15, 15, 1, N + 3);

    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 1'b0;
    #1 check_all_zero("reset_u0");
    sel = 1'b1;
    #1 check_all_zero("reset_u2");
    @(posedge clk); #1;
    rst = 1'b0;

    run(1'b0, 0, 50, 0, 0, 1'b1, e_zero);   // exact, extra start mid-sweep ignored
    run(1'b0, 1, 0, 0, 0, 1'b1, e_lsb);     // LSB-dropping multiplier
    run(1'b0, 1, 0, 0, 0, 1'b1, e_lsb);     // restart from DONE repeats identically
    run(1'b0, 1, 0, 0, 120, 1'b0, e_zero);  // reset mid-sweep
    run(1'b0, 1, 0, 0, 0, 1'b1, e_lsb);     // full sweep after reset
    run(1'b1, 2, 0, 0, 0, 1'b1, e_225);     // latency-2, single worst pair
    run(1'b1, 2, 0, 100, 0, 1'b0, e_zero);  // abort wins over simultaneous start
    run(1'b1, 2, 0, 0, 0, 1'b1, e_225);     // clean sweep after abort

    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
